// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
// Contents: FSM state encodings, instruction classes, opcode/funct constants,
// ALU operation codes and datapath mux select codes.
package mc_ctrl_pkg;

  // FSM states; encodings are visible on the debug state port
  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_EX_R  = 5'd2,
    S_WB_R  = 5'd3,
    S_EX_I  = 5'd4,
    S_WB_I  = 5'd5,
    S_MA    = 5'd6,
    S_MRD   = 5'd7,
    S_WB_LW = 5'd8,
    S_MWR   = 5'd9,
    S_BR    = 5'd10,
    S_J     = 5'd11,
    S_JAL   = 5'd12,
    S_JR    = 5'd13,
    S_LUI   = 5'd14,
    S_INT   = 5'd15,
    S_RFE   = 5'd16
  } state_e;

  // Instruction classes produced by the decoder and used for S_ID dispatch
  typedef enum logic [3:0] {
    ClsR,
    ClsJr,
    ClsJalr,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsBne,
    ClsImm,
    ClsJ,
    ClsJal,
    ClsLui,
    ClsEret,
    ClsIllegal
  } inst_cls_e;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpCop0  = 6'h10;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // Function codes (IR[5:0])
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnEret = 6'h18;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;

  // ALU operation codes (single-cycle ALU encoding)
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // Register-file destination select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2rAlu = 2'b00;
  localparam logic [1:0] M2rMdr = 2'b01;
  localparam logic [1:0] M2rPc  = 2'b10;
  localparam logic [1:0] M2rLui = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select
  localparam logic [2:0] PcAlu    = 3'b000;
  localparam logic [2:0] PcAluOut = 3'b001;
  localparam logic [2:0] PcJump   = 3'b010;
  localparam logic [2:0] PcRs     = 3'b011;
  localparam logic [2:0] PcIntVec = 3'b100;
  localparam logic [2:0] PcEpc    = 3'b101;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decoder for the multi-cycle control FSM.
// Ports:
//   op_code   - IR[31:26]
//   funct     - IR[5:0]
//   alu_op    - ALU operation used by the EX/WB states of this instruction
//   inst_cls  - instruction class driving S_ID dispatch
//   legal     - 1 when the instruction is decodable
module alu_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit INT_SUPPORT = 1'b1
) (
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output inst_cls_e  inst_cls,
  output logic       legal
);

  always_comb begin
    alu_op   = AluAdd;
    inst_cls = ClsIllegal;
    case (op_code)
      OpRtype: begin
        inst_cls = ClsR;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnSlt:   alu_op = AluSlt;
          FnNor:   alu_op = AluNor;
          FnXor:   alu_op = AluXor;
          FnSrl:   alu_op = AluSrl;
          FnJr:    inst_cls = ClsJr;
          FnJalr:  inst_cls = ClsJalr;
          default: inst_cls = ClsIllegal;
        endcase
      end
      OpLw:   inst_cls = ClsLw;
      OpSw:   inst_cls = ClsSw;
      OpBeq: begin
        inst_cls = ClsBeq;
        alu_op   = AluSub;
      end
      OpBne: begin
        inst_cls = ClsBne;
        alu_op   = AluSub;
      end
      OpSlti: begin
        inst_cls = ClsImm;
        alu_op   = AluSlt;
      end
      OpAddi: begin
        inst_cls = ClsImm;
        alu_op   = AluAdd;
      end
      OpAndi: begin
        inst_cls = ClsImm;
        alu_op   = AluAnd;
      end
      OpXori: begin
        inst_cls = ClsImm;
        alu_op   = AluXor;
      end
      OpJ:    inst_cls = ClsJ;
      OpJal:  inst_cls = ClsJal;
      OpLui:  inst_cls = ClsLui;
      OpCop0: begin
        // eret only exists when the interrupt logic is built in
        if (INT_SUPPORT && (funct == FnEret)) inst_cls = ClsEret;
      end
      default: inst_cls = ClsIllegal;
    endcase
  end

  assign legal = (inst_cls != ClsIllegal);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over shared ALU,
// memory and register-file ports, waits on mem_ready, and handles a single
// external interrupt (EPC save) with eret return.
// Ports:
//   clk, rst_n               - clock (rising edge), async active-low reset
//   OP_code, function_code   - instruction fields from the IR
//   zero                     - ALU zero flag (branch resolution)
//   mem_ready                - memory access completes this cycle
//   int_req                  - level-sensitive interrupt request
//   PC_write .. PCSource     - datapath enables and mux selects
//   EPC_write, int_ack       - interrupt entry controls
//   illegal_inst             - one-cycle pulse on an undecodable instruction
//   state                    - current FSM state for debug
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit INT_SUPPORT = 1'b1,
  parameter bit INT_EN_RST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OP_code,
  input  logic [5:0] function_code,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       int_req,
  output logic       PC_write,
  output logic       IorD,
  output logic       mem_read,
  output logic       mem_w,
  output logic       IR_write,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       reg_we,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_operation,
  output logic [2:0] PCSource,
  output logic       EPC_write,
  output logic       int_ack,
  output logic       illegal_inst,
  output logic [4:0] state
);

  state_e    state_q, state_d;
  logic      int_en_q, int_en_d;
  logic [2:0] dec_op;
  inst_cls_e dec_cls;
  logic      dec_legal;
  logic      take_int;
  state_e    done_next;

  alu_op_decode #(
    .INT_SUPPORT(INT_SUPPORT)
  ) u_alu_op_decode (
    .op_code (OP_code),
    .funct   (function_code),
    .alu_op  (dec_op),
    .inst_cls(dec_cls),
    .legal   (dec_legal)
  );

  // Interrupts are only sampled by completing states (instruction boundary)
  assign take_int  = INT_SUPPORT && int_en_q && int_req;
  assign done_next = take_int ? S_INT : S_IF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IF;
      int_en_q <= INT_EN_RST;
    end else begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    int_en_d      = int_en_q;
    PC_write      = 1'b0;
    IorD          = 1'b0;
    mem_read      = 1'b0;
    mem_w         = 1'b0;
    IR_write      = 1'b0;
    RegDst        = RegDstRt;
    MemtoReg      = M2rAlu;
    reg_we        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SrcBRt;
    ALU_operation = AluAnd;
    PCSource      = PcAlu;
    EPC_write     = 1'b0;
    int_ack       = 1'b0;
    illegal_inst  = 1'b0;

    unique case (state_q)
      S_IF: begin
        mem_read      = 1'b1;
        ALUSrcB       = SrcBFour;
        ALU_operation = AluAdd;
        // PC+4 and IR load happen in the cycle the fetch completes
        PC_write      = mem_ready;
        IR_write      = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut
        ALUSrcB       = SrcBImmSh;
        ALU_operation = AluAdd;
        if (!dec_legal) begin
          illegal_inst = 1'b1;
          state_d      = S_IF;
        end else begin
          case (dec_cls)
            ClsR:           state_d = S_EX_R;
            ClsJr, ClsJalr: state_d = S_JR;
            ClsLw, ClsSw:   state_d = S_MA;
            ClsBeq, ClsBne: state_d = S_BR;
            ClsImm:         state_d = S_EX_I;
            ClsJ:           state_d = S_J;
            ClsJal:         state_d = S_JAL;
            ClsLui:         state_d = S_LUI;
            ClsEret:        state_d = S_RFE;
            default:        state_d = S_IF;
          endcase
        end
      end
      S_EX_R: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SrcBRt;
        ALU_operation = dec_op;
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        reg_we        = 1'b1;
        RegDst        = RegDstRd;
        MemtoReg      = M2rAlu;
        ALU_operation = dec_op;
        state_d       = done_next;
      end
      S_EX_I: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SrcBImm;
        ALU_operation = dec_op;
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        reg_we        = 1'b1;
        RegDst        = RegDstRt;
        MemtoReg      = M2rAlu;
        ALU_operation = dec_op;
        state_d       = done_next;
      end
      S_MA: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SrcBImm;
        ALU_operation = AluAdd;
        state_d       = (dec_cls == ClsSw) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read      = 1'b1;
        IorD          = 1'b1;
        ALU_operation = AluAdd;
        if (mem_ready) state_d = S_WB_LW;
      end
      S_WB_LW: begin
        reg_we        = 1'b1;
        RegDst        = RegDstRt;
        MemtoReg      = M2rMdr;
        ALU_operation = AluAdd;
        state_d       = done_next;
      end
      S_MWR: begin
        mem_w         = 1'b1;
        IorD          = 1'b1;
        ALU_operation = AluAdd;
        if (mem_ready) state_d = done_next;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SrcBRt;
        ALU_operation = AluSub;
        PCSource      = PcAluOut;
        PC_write      = (dec_cls == ClsBne) ? ~zero : zero;
        state_d       = done_next;
      end
      S_J: begin
        PC_write = 1'b1;
        PCSource = PcJump;
        state_d  = done_next;
      end
      S_JAL: begin
        PC_write = 1'b1;
        PCSource = PcJump;
        reg_we   = 1'b1;
        RegDst   = RegDstRa;
        MemtoReg = M2rPc;
        state_d  = done_next;
      end
      S_JR: begin
        PC_write = 1'b1;
        PCSource = PcRs;
        if (dec_cls == ClsJalr) begin
          reg_we   = 1'b1;
          RegDst   = RegDstRd;
          MemtoReg = M2rPc;
        end
        state_d = done_next;
      end
      S_LUI: begin
        reg_we   = 1'b1;
        RegDst   = RegDstRt;
        MemtoReg = M2rLui;
        state_d  = done_next;
      end
      S_INT: begin
        EPC_write = 1'b1;
        int_ack   = 1'b1;
        PC_write  = 1'b1;
        PCSource  = PcIntVec;
        int_en_d  = 1'b0;
        state_d   = S_IF;
      end
      S_RFE: begin
        PC_write = 1'b1;
        PCSource = PcEpc;
        int_en_d = 1'b1;
        // int_en is being re-enabled this cycle, so a pending request is
        // taken straight away rather than waiting on the registered flag
        state_d  = (INT_SUPPORT && int_req) ? S_INT : S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard testbench for multi_cycle_ctrl: the stimulus process pushes the
// expected state and output vector for every cycle it drives, and a monitor
// pops and compares on each falling clock edge.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OP_code, function_code;
  logic       zero, mem_ready, int_req;
  logic       PC_write, IorD, mem_read, mem_w, IR_write;
  logic [1:0] RegDst, MemtoReg, ALUSrcB;
  logic       reg_we, ALUSrcA;
  logic [2:0] ALU_operation, PCSource;
  logic       EPC_write, int_ack, illegal_inst;
  logic [4:0] state;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(
    .INT_SUPPORT(1'b1),
    .INT_EN_RST (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .OP_code      (OP_code),
    .function_code(function_code),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .int_req      (int_req),
    .PC_write     (PC_write),
    .IorD         (IorD),
    .mem_read     (mem_read),
    .mem_w        (mem_w),
    .IR_write     (IR_write),
    .RegDst       (RegDst),
    .MemtoReg     (MemtoReg),
    .reg_we       (reg_we),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALU_operation(ALU_operation),
    .PCSource     (PCSource),
    .EPC_write    (EPC_write),
    .int_ack      (int_ack),
    .illegal_inst (illegal_inst),
    .state        (state)
  );

  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_w, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_we, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op, pc_src;
    logic       epc_write, int_ack, illegal;
  } out_t;

  typedef struct {
    string      nm;
    logic [4:0] st;
    out_t       v;
    bit         alu_dc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  out_t got;

  assign got = {PC_write, IorD, mem_read, mem_w, IR_write, RegDst, MemtoReg, reg_we, ALUSrcA,
                ALUSrcB, ALU_operation, PCSource, EPC_write, int_ack, illegal_inst};

  // Monitor: one expected record per driven cycle, checked mid-cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    out_t g, w;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got;
      w = e.v;
      if (e.alu_dc) begin
        g.alu_op = 3'b000;
        w.alu_op = 3'b000;
      end
      n_tests = n_tests + 1;
      if (state !== e.st || g !== w) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got state=%0d outputs=%h, expected state=%0d outputs=%h",
                 e.nm, state, g, e.st, w);
      end
    end
  end

  // Hand-written per-state output values; Mealy and per-instruction terms are
  // patched in by the caller.
  function automatic out_t base(input logic [4:0] st);
    out_t o;
    o = '0;
    case (st)
      5'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b010; end
      5'd1:  begin o.alu_src_b = 2'b11; o.alu_op = 3'b010; end
      5'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b00; end
      5'd3:  begin o.reg_we = 1; o.reg_dst = 2'b01; end
      5'd4:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      5'd5:  begin o.reg_we = 1; end
      5'd6:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b010; end
      5'd7:  begin o.mem_read = 1; o.iord = 1; end
      5'd8:  begin o.reg_we = 1; o.mem_to_reg = 2'b01; end
      5'd9:  begin o.mem_w = 1; o.iord = 1; end
      5'd10: begin o.alu_src_a = 1; o.alu_op = 3'b110; o.pc_src = 3'b001; end
      5'd11: begin o.pc_write = 1; o.pc_src = 3'b010; end
      5'd12: begin
        o.pc_write = 1; o.pc_src = 3'b010; o.reg_we = 1; o.reg_dst = 2'b10;
        o.mem_to_reg = 2'b10;
      end
      5'd13: begin o.pc_write = 1; o.pc_src = 3'b011; end
      5'd14: begin o.reg_we = 1; o.mem_to_reg = 2'b11; end
      5'd15: begin o.epc_write = 1; o.int_ack = 1; o.pc_write = 1; o.pc_src = 3'b100; end
      5'd16: begin o.pc_write = 1; o.pc_src = 3'b101; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic out_t with_op(input logic [4:0] st, input logic [2:0] op);
    out_t o;
    o = base(st);
    o.alu_op = op;
    return o;
  endfunction

  task automatic cyc(input string nm, input logic [4:0] st, input out_t v, input bit alu_dc);
    exp_t e;
    e.nm = nm; e.st = st; e.v = v; e.alu_dc = alu_dc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // IF with wait_n stalled cycles, then the completing fetch cycle
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int wait_n);
    out_t o;
    OP_code = op;
    function_code = fn;
    for (int i = 0; i < wait_n; i++) begin
      mem_ready = 1'b0;
      cyc("if_wait", 5'd0, base(5'd0), 1'b0);
    end
    mem_ready = 1'b1;
    o = base(5'd0);
    o.pc_write = 1;
    o.ir_write = 1;
    cyc("if_done", 5'd0, o, 1'b0);
    mem_ready = 1'b0;
  endtask

  task automatic decode(input string nm, input bit illegal);
    out_t o;
    o = base(5'd1);
    o.illegal = illegal;
    cyc(nm, 5'd1, o, 1'b0);
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [2:0] op);
    fetch(6'h00, fn, 0);
    decode("id_r", 1'b0);
    cyc("ex_r", 5'd2, with_op(5'd2, op), 1'b0);
    cyc("wb_r", 5'd3, with_op(5'd3, op), 1'b0);
  endtask

  task automatic run_i(input logic [5:0] opc, input logic [2:0] op);
    fetch(opc, 6'h00, 0);
    decode("id_i", 1'b0);
    cyc("ex_i", 5'd4, with_op(5'd4, op), 1'b0);
    cyc("wb_i", 5'd5, with_op(5'd5, op), 1'b0);
  endtask

  task automatic run_br(input logic [5:0] opc, input logic z, input logic pcw);
    out_t o;
    fetch(opc, 6'h00, 0);
    decode("id_br", 1'b0);
    zero = z;
    o = base(5'd10);
    o.pc_write = pcw;
    cyc("br", 5'd10, o, 1'b0);
    zero = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] st, input out_t o);
    fetch(opc, fn, 0);
    decode("id", 1'b0);
    cyc(nm, st, o, 1'b0);
  endtask

  logic [5:0] r_fn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h02};
  logic [2:0] r_op [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b011, 3'b101};
  logic [5:0] i_opc[4] = '{6'h08, 6'h0a, 6'h0c, 6'h0e};
  logic [2:0] i_op [4] = '{3'b010, 3'b111, 3'b000, 3'b011};

  initial begin : stim
    out_t o;
    rst_n = 1'b0;
    OP_code = '0; function_code = '0;
    zero = 1'b0; mem_ready = 1'b0; int_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds S_IF decode
    cyc("reset", 5'd0, base(5'd0), 1'b0);
    rst_n = 1'b1;

    // Fetch stall then add
    fetch(6'h00, 6'h20, 2);
    decode("id_add", 1'b0);
    cyc("ex_add", 5'd2, with_op(5'd2, 3'b010), 1'b0);
    cyc("wb_add", 5'd3, with_op(5'd3, 3'b010), 1'b0);

    for (int i = 0; i < 8; i++) run_r(r_fn[i], r_op[i]);
    for (int i = 0; i < 4; i++) run_i(i_opc[i], i_op[i]);

    // lw with two stalled memory cycles
    fetch(6'h23, 6'h00, 0);
    decode("id_lw", 1'b0);
    cyc("ma_lw", 5'd6, base(5'd6), 1'b0);
    cyc("mrd_wait1", 5'd7, base(5'd7), 1'b1);
    cyc("mrd_wait2", 5'd7, base(5'd7), 1'b1);
    mem_ready = 1'b1;
    cyc("mrd_done", 5'd7, base(5'd7), 1'b1);
    mem_ready = 1'b0;
    cyc("wb_lw", 5'd8, base(5'd8), 1'b1);

    // sw with one stalled memory cycle
    fetch(6'h2b, 6'h00, 0);
    decode("id_sw", 1'b0);
    cyc("ma_sw", 5'd6, base(5'd6), 1'b0);
    cyc("mwr_wait", 5'd9, base(5'd9), 1'b1);
    mem_ready = 1'b1;
    cyc("mwr_done", 5'd9, base(5'd9), 1'b1);
    mem_ready = 1'b0;

    run_br(6'h04, 1'b1, 1'b1);
    run_br(6'h04, 1'b0, 1'b0);
    run_br(6'h05, 1'b1, 1'b0);
    run_br(6'h05, 1'b0, 1'b1);

    run_one("j", 6'h02, 6'h00, 5'd11, base(5'd11));
    run_one("jal", 6'h03, 6'h00, 5'd12, base(5'd12));
    run_one("jr", 6'h00, 6'h08, 5'd13, base(5'd13));
    o = base(5'd13);
    o.reg_we = 1; o.reg_dst = 2'b01; o.mem_to_reg = 2'b10;
    run_one("jalr", 6'h00, 6'h09, 5'd13, o);
    run_one("lui", 6'h0f, 6'h00, 5'd14, base(5'd14));

    // Illegal opcode and illegal R-type funct
    fetch(6'h3f, 6'h00, 0);
    decode("id_illegal_op", 1'b1);
    fetch(6'h00, 6'h3f, 1);
    decode("id_illegal_fn", 1'b1);

    // Interrupt raised at WB of add
    fetch(6'h00, 6'h20, 1);
    decode("id_add_int", 1'b0);
    cyc("ex_add_int", 5'd2, with_op(5'd2, 3'b010), 1'b0);
    int_req = 1'b1;
    cyc("wb_add_int", 5'd3, with_op(5'd3, 3'b010), 1'b0);
    cyc("int_entry", 5'd15, base(5'd15), 1'b0);
    // Interrupts now disabled: request stays high but add completes to S_IF
    run_r(6'h20, 3'b010);
    // eret with request pending goes straight to S_INT
    fetch(6'h10, 6'h18, 0);
    decode("id_eret", 1'b0);
    cyc("rfe", 5'd16, base(5'd16), 1'b0);
    cyc("int_after_rfe", 5'd15, base(5'd15), 1'b0);
    int_req = 1'b0;
    fetch(6'h10, 6'h18, 0);
    decode("id_eret2", 1'b0);
    cyc("rfe2", 5'd16, base(5'd16), 1'b0);

    // Reset in the middle of a lw
    fetch(6'h23, 6'h00, 0);
    decode("id_lw_rst", 1'b0);
    cyc("ma_lw_rst", 5'd6, base(5'd6), 1'b0);
    cyc("mrd_lw_rst", 5'd7, base(5'd7), 1'b1);
    rst_n = 1'b0;
    cyc("mid_reset", 5'd0, base(5'd0), 1'b0);
    cyc("mid_reset_hold", 5'd0, base(5'd0), 1'b0);
    rst_n = 1'b1;
    run_r(6'h22, 3'b110);
    mem_ready = 1'b0;
    cyc("final_if", 5'd0, base(5'd0), 1'b0);

    repeat (2) @(posedge clk);
    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Control FSM for the multi-cycle MIPS datapath that replaces the single-cycle decoder. It sequences IF/ID/EX/MEM/WB over shared ALU, memory and register-file ports, and waits on a memory ready handshake. It also handles one external interrupt with an EPC save and an eret return. It sits between the instruction register, the memory interface and the datapath muxes.

Parameters:
INT_SUPPORT, 1, 1 = interrupt/eret logic present; 0 = int_req ignored, eret treated as illegal
INT_EN_RST, 1, reset value of internal interrupt-enable flag

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
OP_code  in  6  IR[31:26], stable after IF
function_code  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
int_req  in  1  level interrupt request
PC_write  out  1  PC load enable
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_w  out  1  memory write strobe
IR_write  out  1  instruction register load
RegDst  out  2  00 = rt, 01 = rd, 10 = $31
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC, 11 = imm<<16
reg_we  out  1  register-file write enable
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALU_operation  out  3  ALU op code (same encoding as the single-cycle ALU)
PCSource  out  3  000 = ALU, 001 = ALUOut, 010 = jump target, 011 = rs, 100 = int vector, 101 = EPC
EPC_write  out  1  load EPC with PC
int_ack  out  1  interrupt taken, one cycle
illegal_inst  out  1  undecodable instruction, one cycle
state  out  5  current state, for debug

Behaviour:
- Registered state; outputs are a combinational decode of state, plus the Mealy terms noted below.
- Reset (async, rst_n = 0): state = S_IF; int_en = INT_EN_RST. Outputs take the S_IF decode: mem_read = 1, ALUSrcB = 01, ALU_operation = 010; all other outputs 0. A reset mid-instruction abandons it with no partial writes after reset.
- States and encodings: S_IF 0, S_ID 1, S_EX_R 2, S_WB_R 3, S_EX_I 4, S_WB_I 5, S_MA 6, S_MRD 7, S_WB_LW 8, S_MWR 9, S_BR 10, S_J 11, S_JAL 12, S_JR 13, S_LUI 14, S_INT 15, S_RFE 16.
- S_IF: mem_read = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, op 010. PC_write = IR_write = mem_ready (Mealy). Stays in S_IF while mem_ready = 0, else goes to S_ID.
- S_ID: ALUSrcA = 0, ALUSrcB = 11, op 010 (branch target into ALUOut). Dispatch:
  - R-type add/sub/and/or/slt/nor/xor/srl -> S_EX_R; jr/jalr -> S_JR.
  - lw/sw -> S_MA; beq/bne -> S_BR; slti/addi/andi/xori -> S_EX_I.
  - j -> S_J; jal -> S_JAL; lui -> S_LUI; eret (OP 6'h10, funct 6'h18) -> S_RFE.
  - Anything else: illegal_inst = 1, return to S_IF.
- S_EX_R: ALUSrcA = 1, ALUSrcB = 00, op from funct: add 010, sub 110, and 000, or 001, slt 111, nor 100, xor 011, srl 101.
- S_WB_R: reg_we = 1, RegDst = 01, MemtoReg = 00.
- S_EX_I: ALUSrcA = 1, ALUSrcB = 10, op: slti 111, addi 010, andi 000, xori 011.
- S_WB_I: reg_we = 1, RegDst = 00, MemtoReg = 00.
- S_MA: ALUSrcA = 1, ALUSrcB = 10, op 010; goes to S_MRD (lw) or S_MWR (sw).
- S_MRD: mem_read = 1, IorD = 1; waits on mem_ready, then S_WB_LW.
- S_WB_LW: reg_we = 1, RegDst = 00, MemtoReg = 01.
- S_MWR: mem_w = 1, IorD = 1; waits on mem_ready; completes when mem_ready = 1.
- S_BR: ALUSrcA = 1, ALUSrcB = 00, op 110, PCSource = 001. PC_write = zero for beq, ~zero for bne (Mealy).
- S_J: PC_write = 1, PCSource = 010.
- S_JAL: as S_J plus reg_we = 1, RegDst = 10, MemtoReg = 10.
- S_JR: PC_write = 1, PCSource = 011. For jalr also reg_we = 1, RegDst = 01, MemtoReg = 10.
- S_LUI: reg_we = 1, RegDst = 00, MemtoReg = 11.
- S_INT: EPC_write = 1, int_ack = 1, PC_write = 1, PCSource = 100; clears int_en; goes to S_IF.
- S_RFE: PC_write = 1, PCSource = 101; sets int_en; goes to S_IF.
- Completing states: S_WB_R, S_WB_I, S_WB_LW, S_MWR (on mem_ready), S_BR, S_J, S_JAL, S_JR, S_LUI, S_RFE.
  - On completion: next = S_INT if INT_SUPPORT & int_en & int_req, else S_IF.
  - The interrupt is taken only at an instruction boundary.
  - A completing S_RFE with int_req already high goes to S_INT directly.
- ALU_operation holds its EX value through WB; 3'b000 in states that do not use the ALU.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode/funct constants, ALU op codes, RegDst/MemtoReg/ALUSrcB/PCSource select codes.
- Sub-module alu_op_decode: combinational OP_code/function_code -> ALU_operation, instruction class, legal flag. It is shared by S_ID dispatch and the EX states.

Test Plan:
- Reset: rst_n = 0 then 1 with mem_ready = 0 -> state stays 0, mem_read = 1, PC_write = 0; mem_ready = 1 -> PC_write = IR_write = 1, next state = 1.
- add (OP 0, funct 6'h20), mem_ready = 1 -> states 0, 1, 2, 3 in 4 cycles; cycle 4: reg_we = 1, RegDst = 01, ALU_operation = 010.
- lw with mem_ready held low 2 cycles in S_MRD -> S_MRD lasts 3 cycles; S_WB_LW: MemtoReg = 01, reg_we = 1; 7 cycles total.
- beq with zero = 1 -> S_BR: PC_write = 1, PCSource = 001; repeat with zero = 0 -> PC_write = 0. bne inverts both.
- int_req = 1 during S_WB_R of add -> next S_INT: EPC_write = int_ack = 1, PCSource = 100. A second int_req is ignored until eret (OP 6'h10, funct 6'h18) executes S_RFE with PCSource = 101.
- OP 6'h3f -> S_ID with illegal_inst = 1 for one cycle, then S_IF; no reg_we, mem_w or PC_write asserted.
